// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: drives per-stage enables and bubble clears,
// tracks multi-cycle MDU ops with a watchdog, and keeps saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  typedef enum logic {RUN, MDU_WAIT} state_e;

  state_e           state_q, state_d;
  logic             done_pend_q, done_pend_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic load_use;
  logic in_mdu;
  logic done_any;
  logic wd_hit;
  logic mdu_hold;
  logic flush_evt;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign in_mdu   = (state_q == MDU_WAIT);
  assign done_any = mdu_done | done_pend_q;
  assign wd_hit   = (wd_cnt_q == WD_LAST);
  // A watchdog expiry releases the wait exactly like a real done would.
  assign mdu_hold = in_mdu ? ~(done_any | wd_hit) : ex_mdu_start;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_clear = 1'b0;
    flush_evt    = 1'b0;
    if (mem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_clear = 1'b1;
    end else if (mdu_hold) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_clear = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_clear = 1'b1;
    end
    // Hold the whole pipeline frozen while reset is asserted.
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_clear  = 1'b0;
      id_ex_clear  = 1'b0;
      ex_mem_clear = 1'b0;
      mem_wb_clear = 1'b0;
      flush_evt    = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (ex_mdu_start && !mem_wait) begin
          state_d  = MDU_WAIT;
          wd_cnt_d = '0;
        end
      end
      MDU_WAIT: begin
        if (!wd_hit) wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (wd_hit && !done_any) timeout_d = 1'b1;
        if (!mem_wait && (done_any || wd_hit)) begin
          state_d     = RUN;
          done_pend_d = 1'b0;
        end else if (mdu_done) begin
          // Done arrived while memory stalls us; remember it for release.
          done_pend_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mdu_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: a stimulus process queues expected
// responses and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] idRs1, idRs2, exRd;
  logic       idUseRs1, idUseRs2, exMemRead, exBranchTaken, exMduStart;
  logic       mduDone, memReq, memReady;

  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        ifIdClr, idExClr, exMemClr, memWbClr, mduTo;
  logic [31:0] stallCnt, flushCnt;

  logic        sPcEn, sIfIdEn, sIdExEn, sExMemEn, sMemWbEn;
  logic        sIfIdClr, sIdExClr, sExMemClr, sMemWbClr, sMduTo;
  logic [1:0]  sStallCnt, sFlushCnt;

  hazard_ctrl #(.CNT_W(32), .MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
    .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .ex_mdu_start(exMduStart), .mdu_done(mduDone), .mem_req(memReq), .mem_ready(memReady),
    .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn), .ex_mem_en(exMemEn), .mem_wb_en(memWbEn),
    .if_id_clear(ifIdClr), .id_ex_clear(idExClr), .ex_mem_clear(exMemClr), .mem_wb_clear(memWbClr),
    .mdu_timeout(mduTo), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  // Narrow-counter copy sharing the same inputs, used to observe saturation.
  hazard_ctrl #(.CNT_W(2), .MDU_TIMEOUT(8)) dutSat (
    .clk(clk), .rst(rst),
    .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
    .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .ex_mdu_start(exMduStart), .mdu_done(mduDone), .mem_req(memReq), .mem_ready(memReady),
    .pc_en(sPcEn), .if_id_en(sIfIdEn), .id_ex_en(sIdExEn), .ex_mem_en(sExMemEn), .mem_wb_en(sMemWbEn),
    .if_id_clear(sIfIdClr), .id_ex_clear(sIdExClr), .ex_mem_clear(sExMemClr), .mem_wb_clear(sMemWbClr),
    .mdu_timeout(sMduTo), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] exrd;
    logic       memrd, br, mdus, done, memreq, memrdy;
    logic [4:0] expEn;
    logic [3:0] expClr;
    logic       expTo;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  en;
    logic [3:0]  clr;
    logic        to;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [1:0]  sStall;
    logic [1:0]  sFlush;
  } exp_t;

  vec_t tbl[$];
  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   vecIdx = 0;
  int   mStall = 0;
  int   mFlush = 0;

  function automatic vec_t mk(input int rstn, input int rs1, input int rs2, input int u1,
                              input int u2, input int exrd, input int memrd, input int br,
                              input int mdus, input int done, input int memreq, input int memrdy,
                              input logic [4:0] en, input logic [3:0] clr, input int to);
    vec_t v;
    v.rstn = rstn[0]; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.use1 = u1[0]; v.use2 = u2[0];
    v.exrd = exrd[4:0]; v.memrd = memrd[0]; v.br = br[0]; v.mdus = mdus[0]; v.done = done[0];
    v.memreq = memreq[0]; v.memrdy = memrdy[0]; v.expEn = en; v.expClr = clr; v.expTo = to[0];
    return v;
  endfunction

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  // Drive one cycle of inputs after the edge and queue what the DUT must show.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rstn; idRs1 = v.rs1; idRs2 = v.rs2; idUseRs1 = v.use1; idUseRs2 = v.use2;
    exRd = v.exrd; exMemRead = v.memrd; exBranchTaken = v.br; exMduStart = v.mdus;
    mduDone = v.done; memReq = v.memreq; memReady = v.memrdy;
    if (!v.rstn) begin
      mStall = 0;
      mFlush = 0;
    end
    e.idx = vecIdx; e.en = v.expEn; e.clr = v.expClr; e.to = v.expTo;
    e.stall = mStall; e.flush = mFlush; e.sStall = sat2(mStall); e.sFlush = sat2(mFlush);
    scb.push_back(e);
    if (v.rstn) begin
      if (!v.expEn[4]) mStall++;
      if (v.expClr[3]) mFlush++;
    end
    vecIdx++;
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s vec %0d actual %0h required %0h", name, idx, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("enables", e.idx, {27'd0, pcEn, ifIdEn, idExEn, exMemEn, memWbEn}, {27'd0, e.en});
    cmp("clears", e.idx, {28'd0, ifIdClr, idExClr, exMemClr, memWbClr}, {28'd0, e.clr});
    cmp("mdu_timeout", e.idx, {31'd0, mduTo}, {31'd0, e.to});
    cmp("stall_cnt", e.idx, stallCnt, e.stall);
    cmp("flush_cnt", e.idx, flushCnt, e.flush);
    cmp("stall_cnt_sat", e.idx, {30'd0, sStallCnt}, {30'd0, e.sStall});
    cmp("flush_cnt_sat", e.idx, {30'd0, sFlushCnt}, {30'd0, e.sFlush});
  endtask

  // Monitor: outputs are combinational, so each queued vector is visible mid-cycle.
  always @(negedge clk) begin
    if (scb.size() > 0) checkOutput(scb.pop_front());
  end

  initial begin
    rst = 1'b0; idRs1 = '0; idRs2 = '0; exRd = '0; idUseRs1 = 0; idUseRs2 = 0;
    exMemRead = 0; exBranchTaken = 0; exMduStart = 0; mduDone = 0; memReq = 0; memReady = 1;

    //            rn rs1 rs2 u1 u2 rd mr br ms dn rq ry   en        clr      to
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0)); // 0 reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1, 5'b00111, 4'b0100, 0)); // 3 load-use rs1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0, 1, 5'b00111, 4'b0100, 0)); // 5 load-use rs2
    tbl.push_back(mk(1, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0)); // rs1 unused
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0)); // rd = x0
    tbl.push_back(mk(1, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0)); // not a load
    tbl.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 5'b11111, 4'b1100, 0)); // 9 branch+lu
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 4'b0001, 0)); // 11 mem wait
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5'b00001, 4'b0001, 0)); // branch ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00011, 4'b0010, 0)); // 14 MDU start
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 4'b0010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11111, 4'b0000, 0)); // 18 done
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11111, 4'b0000, 0)); // stray done
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00011, 4'b0010, 0)); // 21 MDU start
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 4'b0001, 0)); // done in wait
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 4'b0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 4'b0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 4'b0000, 0)); // 25 release
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00001, 4'b0001, 0)); // 27 start held
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00011, 4'b0010, 0)); // 29 watchdog
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 4'b0010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0)); // 37 forced exit
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00011, 4'b0010, 1)); // 39
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 4'b0010, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0)); // 41 reset mid-wait
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11111, 4'b0000, 0)); // stray done
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b11111, 4'b1100, 0)); // 44 branch
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 5'b00011, 4'b0010, 0)); // 46 br+mdu
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 4'b0000, 0));

    foreach (tbl[i]) applyStimulus(tbl[i]);

    for (int k = 0; k < 10 && scb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (scb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending %0d required 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the en/clear pair of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves load-use hazards, taken-branch flushes, multi-cycle MDU ops and data-memory wait states. It keeps saturating stall/flush performance counters and an MDU watchdog.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt (saturating)
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before forced release

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
id_rs1  in  5  source reg 1 of instr in ID
id_rs2  in  5  source reg 2 of instr in ID
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_rd  in  5  dest reg of instr in EX
ex_mem_read  in  1  EX instr is a load
ex_branch_taken  in  1  EX resolved taken branch/jump (redirect)
ex_mdu_start  in  1  EX instr is MUL/DIV; unit starts this cycle
mdu_done  in  1  one-cycle pulse, MDU result valid
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear  out  1 each  bubble inject
mdu_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst=0, async): state=RUN, done_pend=0, wd_cnt=0, mdu_timeout=0, counters=0. While rst=0 all enables=0 and all clears=0.
- States: RUN, MDU_WAIT. mem_wait = mem_req & ~mem_ready. load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Outputs are combinational from state + inputs. Default: all en=1, all clear=0.
- Priority (highest first):
  1. mem_wait (any state): all en=0 except mem_wb_en=1 with mem_wb_clear=1 (bubble to WB). Branch, load_use and MDU start are ignored this cycle and re-evaluated once released.
  2. MDU_WAIT, or RUN with ex_mdu_start: pc/if_id/id_ex en=0; ex_mem_clear=1; mem_wb_en=1.
  3. ex_branch_taken: if_id_clear=1, id_ex_clear=1, pc_en=1 (target load).
  4. load_use: pc_en=0, if_id_en=0, id_ex_clear=1.
- Simultaneous ex_branch_taken and ex_mdu_start is illegal. If it occurs, the MDU path wins.
- Transitions:
  - RUN to MDU_WAIT when ex_mdu_start & ~mem_wait.
  - MDU_WAIT to RUN in the first cycle where (mdu_done | done_pend) & ~mem_wait. In that cycle all en=1 and clears=0 (EX/MEM captures the result), subject to priority 3/4 for ID.
- done_pend: set on mdu_done while mem_wait in MDU_WAIT; cleared on exit from MDU_WAIT.
- Watchdog: wd_cnt clears on MDU_WAIT entry and increments each MDU_WAIT cycle. When wd_cnt == MDU_TIMEOUT-1 and no done: set mdu_timeout (sticky until reset) and force exit to RUN as if done.
- stall_cnt increments every cycle pc_en=0 (rst=1). flush_cnt increments on each cycle priority 3 is active. Both saturate at all-ones.
- Reset mid-MDU_WAIT returns to RUN immediately. Any later stray mdu_done is ignored in RUN.
- Latency: load-use costs exactly 1 stall cycle. A branch costs 2 flushed slots. An MDU op of N cycles costs N stall cycles.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_clear=1; stall_cnt=1.
- ex_rd=0 with matching rs1 -> no stall, all en=1.
- Branch plus load-use same cycle -> if_id_clear=id_ex_clear=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- MDU: ex_mdu_start at cycle 0, mdu_done at cycle 4 -> pc_en=0 cycles 0-3, ex_mem_clear=1 cycles 0-3, all en=1 at cycle 4, state RUN at cycle 5.
- mdu_done during mem_wait (mem_ready low for 3 cycles) -> MEM/WB bubbles for 3 cycles, done_pend=1; release on the first cycle mem_ready=1 with ex_mem_en=1.
- MDU_TIMEOUT=8, no done -> mdu_timeout=1 after 8 MDU_WAIT cycles, state RUN; rst low mid-wait -> immediate RUN with counters and flag cleared.
